// File: rtl/grain_stream_ctrl.sv
// Grain-128a session controller: key/IV latch, core reset/warm-up sequencing,
// keystream bit packing and output FIFO. Optional word limit: GRAIN_CTRL_LIMIT_EN.
module grain_stream_ctrl #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [127:0]      start_key,
    input  logic [95:0]       start_iv,
    input  logic              stop,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic [WORD_W-1:0] ks_data,
    output logic              busy,
    output logic              overrun,
    output logic [31:0]       words_out,
    output logic              core_n_reset,
    output logic              core_enable,
    output logic [127:0]      core_key,
    output logic [95:0]       core_iv,
    input  logic              core_key_stream,
    input  logic              core_ready
);

    localparam int BC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      LIMIT_W  = 32'(MAX_WORDS);
`ifdef GRAIN_CTRL_LIMIT_EN
    localparam logic LIMIT_ON = 1'b1;
`else
    localparam logic LIMIT_ON = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARM   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]        state_r;
    logic [127:0]      key_r;
    logic [95:0]       iv_r;
    logic              overrun_r;
    logic [31:0]       words_r;
    logic              n_reset_r;
    logic [BC_W-1:0]   bit_cnt_r;
    logic [WORD_W-1:0] pack_r;
    logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              start_fire_s;
    logic              pop_s;
    logic              full_s;
    logic              in_stream_s;
    logic              word_done_s;
    logic [WORD_W-1:0] word_s;
    logic              push_s;
    logic              drop_s;
    logic [31:0]       words_inc_s;
    logic              limit_hit_s;
    logic              end_s;
    logic [1:0]        next_state_s;

    // Session control decode and next-state selection
    always_comb begin
        start_fire_s = start_valid && (state_r == ST_IDLE) && (count_r == {CNT_W{1'b0}});
        pop_s        = (count_r != {CNT_W{1'b0}}) && ks_ready;
        full_s       = (count_r == FULL_CNT);
        in_stream_s  = (state_r == ST_STREAM);
        word_done_s  = in_stream_s && (bit_cnt_r == LAST_BIT);
        word_s            = pack_r;
        word_s[bit_cnt_r] = core_key_stream;
        // A full FIFO can still take the word when the consumer pops in the same cycle.
        push_s       = word_done_s && (!full_s || pop_s);
        drop_s       = word_done_s && full_s && !pop_s;
        words_inc_s  = words_r + 32'd1;
        limit_hit_s  = LIMIT_ON && push_s && (words_inc_s == LIMIT_W);
        end_s        = in_stream_s && (stop || drop_s || limit_hit_s);
        case (state_r)
            ST_IDLE: begin
                if (start_fire_s) begin
                    next_state_s = ST_WARM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WARM: begin
                if (stop) begin
                    next_state_s = ST_IDLE;
                end else if (core_ready) begin
                    next_state_s = ST_STREAM;
                end else begin
                    next_state_s = ST_WARM;
                end
            end
            ST_STREAM: begin
                if (end_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Session state, latched key/IV, status counters and bit packer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            key_r     <= 128'd0;
            iv_r      <= 96'd0;
            overrun_r <= 1'b0;
            words_r   <= 32'd0;
            n_reset_r <= 1'b0;
            bit_cnt_r <= {BC_W{1'b0}};
            pack_r    <= {WORD_W{1'b0}};
        end else begin
            state_r   <= next_state_s;
            n_reset_r <= (next_state_s != ST_IDLE);
            if (start_fire_s) begin
                key_r     <= start_key;
                iv_r      <= start_iv;
                overrun_r <= 1'b0;
                words_r   <= 32'd0;
            end else begin
                if (drop_s) begin
                    overrun_r <= 1'b1;
                end
                if (push_s) begin
                    words_r <= words_inc_s;
                end
            end
            // Any session end discards the partial word.
            if (in_stream_s && !end_s) begin
                if (word_done_s) begin
                    bit_cnt_r <= {BC_W{1'b0}};
                    pack_r    <= {WORD_W{1'b0}};
                end else begin
                    bit_cnt_r <= bit_cnt_r + BC_W'(1);
                    pack_r    <= word_s;
                end
            end else begin
                bit_cnt_r <= {BC_W{1'b0}};
                pack_r    <= {WORD_W{1'b0}};
            end
        end
    end

    // Output word FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign start_ready  = (state_r == ST_IDLE) && (count_r == {CNT_W{1'b0}});
    assign ks_valid     = (count_r != {CNT_W{1'b0}});
    assign ks_data      = mem_r[rd_ptr_r];
    assign busy         = (state_r != ST_IDLE);
    assign overrun      = overrun_r;
    assign words_out    = words_r;
    assign core_n_reset = n_reset_r;
    assign core_enable  = (state_r == ST_WARM) || (state_r == ST_STREAM);
    assign core_key     = key_r;
    assign core_iv      = iv_r;

endmodule
